set_pattern_sequencer: RTL and testbench
========================================

Name: set_pattern_sequencer

Overview:
- Synthesizable front-end that feeds the SET candidate-counting core. It drives central/radius/mode with the en/busy handshake and consumes the valid/candidate results.
- Reads pattern and expected-result words from an external synchronous ROM. Issues each pattern to SET, captures the returned candidate, compares it against the expected value, and keeps pass/fail statistics.
- Sits directly upstream of SET and lets on-chip self-test replace the simulation bench.

Parameters:
- NUM_PAT, 64, number of patterns per run (1..256)
- AW, 6, ROM address width; must satisfy 2^AW >= NUM_PAT
- TIMEOUT, 1023, maximum cycles to wait for valid before the pattern is declared failed
- ERR_LIMIT, 10, error count at which the run aborts; 0 disables abort

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE
- mode_sel  in  2  SET function for the whole run; latched at start
- rom_addr  out  AW  pattern index to the ROM
- rom_central  in  24  central word; valid one cycle after rom_addr
- rom_radius  in  12  radius word; same timing as rom_central
- rom_expected  in  8  expected candidate; same timing as rom_central
- set_en  out  1  to SET en
- set_central  out  24  to SET central
- set_radius  out  12  to SET radius
- set_mode  out  2  to SET mode
- set_busy  in  1  from SET busy
- set_valid  in  1  from SET valid
- set_candidate  in  8  from SET candidate
- run_busy  out  1  high from start acceptance until DONE
- done  out  1  high in DONE, held until the next start
- err_cnt  out  8  mismatches plus timeouts in the current run
- pass_cnt  out  8  matching patterns in the current run
- first_fail  out  AW  index of the first failing pattern
- fail_seen  out  1  at least one failure in the run
- aborted  out  1  run ended early because ERR_LIMIT was reached

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; internal index and timeout counter cleared. Reset mid-run abandons the run immediately, with set_en forced 0 asynchronously.
- FSM states: IDLE, FETCH, LOAD, WAIT_IDLE, ISSUE, WAIT_VALID, CHECK, DONE.
- IDLE/DONE + start=1:
  - Latch mode_sel into set_mode.
  - Clear err_cnt, pass_cnt, first_fail, fail_seen, aborted, done; set idx=0 and run_busy=1.
  - Next state FETCH.
- FETCH: rom_addr=idx; next state LOAD.
- LOAD: register rom_central into set_central, rom_radius into set_radius, and rom_expected into exp_reg; next state WAIT_IDLE.
- WAIT_IDLE: stay while set_busy=1; go to ISSUE when set_busy=0.
- ISSUE: set_en=1 for exactly one cycle. set_central and set_radius stay stable from LOAD until the next LOAD. Clear the timeout counter; next state WAIT_VALID.
- WAIT_VALID:
  - set_valid is sampled only in this state; set_valid during ISSUE is ignored.
  - On set_valid=1, capture set_candidate and go to CHECK.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, mark the pattern failed without a compare and go to CHECK.
- CHECK:
  - On match (and no timeout), pass_cnt += 1.
  - On mismatch or timeout, err_cnt += 1. If fail_seen=0, record first_fail=idx and set fail_seen=1.
  - If ERR_LIMIT != 0 and the updated err_cnt == ERR_LIMIT, set aborted=1 and go to DONE.
  - Else if idx == NUM_PAT-1, go to DONE.
  - Else idx += 1 and go to FETCH.
- DONE: run_busy=0, done=1. Counters hold. start begins a new run.
- Count saturation: err_cnt and pass_cnt saturate at 255; no wrap.
- Pattern latency: minimum 5 cycles of sequencer overhead per pattern plus SET processing time.
- start during a run (states FETCH..CHECK) is ignored.
- mode_sel changes during a run have no effect.

Test Plan:
- All match: NUM_PAT=4, ROM expected={3,5,0,8}, SET model returns the same values with busy for 2 cycles -> done=1, pass_cnt=4, err_cnt=0, fail_seen=0, aborted=0. Exactly four single-cycle set_en pulses, each with set_busy=0 in that cycle.
- Single mismatch: pattern 2 returns 7 instead of 0 -> err_cnt=1, pass_cnt=3, first_fail=2, fail_seen=1.
- Timeout: TIMEOUT=15, SET never asserts valid on pattern 1 -> pattern 1 counted as an error 15 cycles after ISSUE; run continues; err_cnt=1, first_fail=1.
- Abort: ERR_LIMIT=2, patterns 0 and 3 mismatch -> DONE after pattern 3 CHECK, aborted=1, err_cnt=2, no set_en for patterns 4 and later.
- Busy handshake: set_busy held high for 20 cycles before pattern 0 -> set_en stays 0 until the first cycle after set_busy falls. A start pulse mid-run is ignored and counters are not cleared.
- Reset mid-run: rst low during WAIT_VALID of pattern 1 -> set_en=0 and all outputs 0 immediately. After release, a new start runs from idx 0.

Source files
------------

// File: rtl/set_pattern_sequencer_if.sv
// set_pattern_sequencer_if: request/response handshake between the sequencer and the SET core
interface set_pattern_sequencer_if;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy;
  logic        valid;
  logic [7:0]  candidate;
  modport master (output en, central, radius, mode, input busy, valid, candidate);
  modport slave  (input en, central, radius, mode, output busy, valid, candidate);
endinterface

// File: rtl/set_pattern_sequencer.sv
// set_pattern_sequencer: ROM-driven self-test front-end that issues patterns to SET and scores the results
module set_pattern_sequencer #(
  parameter int NUM_PAT   = 64,
  parameter int AW        = 6,
  parameter int TIMEOUT   = 1023,
  parameter int ERR_LIMIT = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   mode_sel,
  output logic [AW-1:0]                rom_addr,
  input  logic [23:0]                  rom_central,
  input  logic [11:0]                  rom_radius,
  input  logic [7:0]                   rom_expected,
  set_pattern_sequencer_if.master      set,
  output logic                         run_busy,
  output logic                         done,
  output logic [7:0]                   err_cnt,
  output logic [7:0]                   pass_cnt,
  output logic [AW-1:0]                first_fail,
  output logic                         fail_seen,
  output logic                         aborted
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] FETCH      = 3'd1;
  localparam logic [2:0] LOAD       = 3'd2;
  localparam logic [2:0] WAIT_IDLE  = 3'd3;
  localparam logic [2:0] ISSUE      = 3'd4;
  localparam logic [2:0] WAIT_VALID = 3'd5;
  localparam logic [2:0] CHECK      = 3'd6;
  localparam logic [2:0] DONE       = 3'd7;
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [2:0]    state;
  logic [AW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic [7:0]    exp_reg;
  logic [7:0]    cand;
  logic          timed_out;
  logic          fail;
  logic [7:0]    err_nx;
  logic          hit_limit;
  assign fail      = timed_out || cand != exp_reg;
  assign err_nx    = err_cnt == 8'hff ? err_cnt : err_cnt + 8'd1;
  assign hit_limit = ERR_LIMIT != 0 && err_nx == 8'(ERR_LIMIT);
  assign rom_addr  = idx;
  // Outputs decoded from state so an asynchronous reset drops set_en immediately
  assign set.en    = state == ISSUE;
  assign run_busy  = state != IDLE && state != DONE;
  assign done      = state == DONE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      tcnt        <= '0;
      exp_reg     <= '0;
      cand        <= '0;
      timed_out   <= 1'b0;
      set.central <= '0;
      set.radius  <= '0;
      set.mode    <= '0;
      err_cnt     <= '0;
      pass_cnt    <= '0;
      first_fail  <= '0;
      fail_seen   <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE:
          if (start) begin
            set.mode   <= mode_sel;
            err_cnt    <= '0;
            pass_cnt   <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
            aborted    <= 1'b0;
            idx        <= '0;
            state      <= FETCH;
          end
        FETCH: state <= LOAD;
        LOAD: begin
          set.central <= rom_central;
          set.radius  <= rom_radius;
          exp_reg     <= rom_expected;
          state       <= WAIT_IDLE;
        end
        WAIT_IDLE: state <= set.busy ? WAIT_IDLE : ISSUE;
        ISSUE: begin
          tcnt      <= '0;
          timed_out <= 1'b0;
          state     <= WAIT_VALID;
        end
        WAIT_VALID:
          if (set.valid) begin
            cand  <= set.candidate;
            state <= CHECK;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TW'(TIMEOUT - 1)) begin
              timed_out <= 1'b1;
              state     <= CHECK;
            end
          end
        CHECK: begin
          if (fail) begin
            err_cnt <= err_nx;
            if (!fail_seen) begin
              first_fail <= idx;
              fail_seen  <= 1'b1;
            end
          end else
            pass_cnt <= pass_cnt == 8'hff ? pass_cnt : pass_cnt + 8'd1;
          if (fail && hit_limit) begin
            aborted <= 1'b1;
            state   <= DONE;
          end else if (idx == AW'(NUM_PAT - 1))
            state <= DONE;
          else begin
            idx   <= idx + 1'b1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_set_pattern_sequencer.sv
// tb_set_pattern_sequencer: directed and random runs against a ROM/SET model and a pattern-level scoring model
module tb_set_pattern_sequencer;
  localparam int N = 8, AW = 3, TO = 15, EL = 2;
  logic clk = 0, rst = 0, start = 0;
  logic [1:0] mode_sel = 0, run_mode = 0;
  logic [AW-1:0] rom_addr, first_fail;
  logic [23:0] rom_central;
  logic [11:0] rom_radius;
  logic [7:0] rom_expected, err_cnt, pass_cnt;
  logic run_busy, done, fail_seen, aborted;
  set_pattern_sequencer_if sif();
  set_pattern_sequencer #(.NUM_PAT(N), .AW(AW), .TIMEOUT(TO), .ERR_LIMIT(EL)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_sel(mode_sel), .rom_addr(rom_addr),
    .rom_central(rom_central), .rom_radius(rom_radius), .rom_expected(rom_expected),
    .set(sif), .run_busy(run_busy), .done(done), .err_cnt(err_cnt), .pass_cnt(pass_cnt),
    .first_fail(first_fail), .fail_seen(fail_seen), .aborted(aborted));
  always #5 clk = ~clk;
  logic [23:0] rc [N];
  logic [11:0] rr [N];
  logic [7:0] re [N], resp [N];
  logic nv [N];
  always @(posedge clk) begin
    rom_central  <= rc[rom_addr];
    rom_radius   <= rr[rom_addr];
    rom_expected <= re[rom_addr];
  end
  // SET model: busy for busy_len cycles after each en, then one valid pulse unless nv marks it silent
  int en_cnt = 0, viol = 0, data_err = 0, dbl = 0, run_base = 0, mk = 0, bcnt = 0, busy_len = 2;
  logic m_busy = 0, ext_busy = 0, prev_en = 0;
  assign sif.busy = m_busy | ext_busy;
  initial begin
    sif.valid = 0;
    sif.candidate = 0;
  end
  always @(posedge clk) begin
    sif.valid <= 1'b0;
    if (sif.en) begin
      if (sif.busy) viol++;
      if (prev_en) dbl++;
      mk = en_cnt - run_base;
      if (mk >= N || sif.central !== rc[mk] || sif.radius !== rr[mk] || sif.mode !== run_mode) data_err++;
      en_cnt++;
      m_busy <= 1'b1;
      bcnt = busy_len;
    end else if (m_busy) begin
      bcnt = bcnt - 1;
      if (bcnt == 0) begin
        m_busy <= 1'b0;
        if (mk < N && !nv[mk]) begin
          sif.valid     <= 1'b1;
          sif.candidate <= resp[mk];
        end
      end
    end
    prev_en = sif.en;
  end
  int n_assert = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic ref_run(output int p, output int e, output int ff, output int fs, output int ab, output int iss);
    p = 0; e = 0; ff = 0; fs = 0; ab = 0; iss = 0;
    for (int i = 0; i < N; i++) begin
      iss++;
      if (nv[i] || resp[i] != re[i]) begin
        e++;
        if (fs == 0) begin fs = 1; ff = i; end
        if (e == EL) begin ab = 1; break; end
      end else p++;
    end
  endtask
  task automatic fill(input int mis_pct, input int nv_pct);
    for (int i = 0; i < N; i++) begin
      rc[i] = 24'($urandom); rr[i] = 12'($urandom); re[i] = 8'($urandom);
      resp[i] = ($urandom_range(0, 99) < mis_pct) ? re[i] ^ 8'(1 << $urandom_range(0, 7)) : re[i];
      nv[i] = $urandom_range(0, 99) < nv_pct;
    end
  endtask
  task automatic do_run(input string nm, input bit mid_start, input bit busy_hold);
    int p, e, ff, fs, ab, iss, t, v0, d0, b0;
    ref_run(p, e, ff, fs, ab, iss);
    @(negedge clk);
    mode_sel = 2'($urandom);
    run_mode = mode_sel;
    run_base = en_cnt; v0 = viol; d0 = data_err; b0 = dbl;
    ext_busy = busy_hold;
    start = 1;
    @(negedge clk);
    start = 0;
    mode_sel = ~mode_sel;
    if (busy_hold) begin
      repeat (20) @(negedge clk);
      chk({nm, ".no_en_while_busy"}, en_cnt - run_base, 0);
      ext_busy = 0;
      chk({nm, ".en_low_at_fall"}, sif.en, 0);
      @(negedge clk);
      chk({nm, ".en_after_fall"}, sif.en, 1);
    end
    if (mid_start) begin
      repeat (12) @(negedge clk);
      chk({nm, ".busy_mid"}, run_busy, 1);
      start = 1;
      @(negedge clk);
      start = 0;
    end
    t = 0;
    while (!done && t < 2000) begin @(negedge clk); t++; end
    chk({nm, ".finished"}, t < 2000, 1);
    chk({nm, ".done"}, done, 1);
    chk({nm, ".run_busy"}, run_busy, 0);
    chk({nm, ".pass_cnt"}, pass_cnt, p);
    chk({nm, ".err_cnt"}, err_cnt, e);
    chk({nm, ".first_fail"}, first_fail, ff);
    chk({nm, ".fail_seen"}, fail_seen, fs);
    chk({nm, ".aborted"}, aborted, ab);
    chk({nm, ".en_pulses"}, en_cnt - run_base, iss);
    chk({nm, ".set_mode"}, sif.mode, run_mode);
    chk({nm, ".en_while_busy"}, viol - v0, 0);
    chk({nm, ".issue_data"}, data_err - d0, 0);
    chk({nm, ".en_width"}, dbl - b0, 0);
  endtask
  initial begin
    int t;
    fill(0, 0);
    repeat (3) @(negedge clk);
    chk("rst.rom_addr", rom_addr, 0);
    chk("rst.set_en", sif.en, 0);
    chk("rst.set_central", sif.central, 0);
    chk("rst.set_radius", sif.radius, 0);
    chk("rst.set_mode", sif.mode, 0);
    chk("rst.run_busy", run_busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err_cnt", err_cnt, 0);
    chk("rst.pass_cnt", pass_cnt, 0);
    chk("rst.first_fail", first_fail, 0);
    chk("rst.fail_seen", fail_seen, 0);
    chk("rst.aborted", aborted, 0);
    rst = 1;
    re[0] = 3; re[1] = 5; re[2] = 0; re[3] = 8;
    for (int i = 0; i < N; i++) resp[i] = re[i];
    do_run("all_match", 0, 0);
    resp[2] = 7;
    do_run("mismatch", 1, 0);
    resp[2] = re[2];
    nv[1] = 1;
    do_run("timeout", 0, 0);
    nv[1] = 0;
    resp[0] = re[0] ^ 8'h01;
    resp[3] = re[3] ^ 8'h10;
    do_run("abort", 0, 0);
    for (int i = 0; i < N; i++) resp[i] = re[i];
    do_run("busy_hold", 0, 1);
    @(negedge clk);
    run_base = en_cnt;
    run_mode = mode_sel;
    start = 1;
    @(negedge clk);
    start = 0;
    t = 0;
    while (en_cnt - run_base < 2 && t < 500) begin @(negedge clk); t++; end
    chk("midrst.reached", t < 500, 1);
    rst = 0;
    #1;
    chk("midrst.set_en", sif.en, 0);
    chk("midrst.run_busy", run_busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.pass_cnt", pass_cnt, 0);
    chk("midrst.set_central", sif.central, 0);
    chk("midrst.set_mode", sif.mode, 0);
    chk("midrst.rom_addr", rom_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (40) @(negedge clk);
    do_run("after_rst", 0, 0);
    for (int r = 0; r < 6; r++) begin
      busy_len = $urandom_range(1, 4);
      fill(20, 8);
      do_run($sformatf("rand%0d", r), 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
